// File: rtl/mesh_stream_injector.sv
// Streams a block of local SRAM words into the mesh as remote stores to one tile,
// absorbing the 1-cycle SRAM latency, link backpressure and credit flow control.
module mesh_stream_injector #(
  parameter int x_cord_width_p    = 2,
  parameter int y_cord_width_p    = 2,
  parameter int data_width_p      = 32,
  parameter int addr_width_p      = 10,
  parameter int max_out_credits_p = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      start_i,
  input  logic [addr_width_p-1:0]   src_addr_i,
  input  logic [addr_width_p-1:0]   dst_addr_i,
  input  logic [addr_width_p:0]     len_i,
  input  logic [x_cord_width_p-1:0] my_x_i,
  input  logic [y_cord_width_p-1:0] my_y_i,
  input  logic [x_cord_width_p-1:0] dest_x_i,
  input  logic [y_cord_width_p-1:0] dest_y_i,
  output logic                      mem_v_o,
  output logic [addr_width_p-1:0]   mem_addr_o,
  input  logic [data_width_p-1:0]   mem_data_i,
  output logic                      pkt_v_o,
  input  logic                      pkt_ready_i,
  output logic [addr_width_p-1:0]   pkt_addr_o,
  output logic [data_width_p-1:0]   pkt_data_o,
  output logic [x_cord_width_p-1:0] pkt_x_o,
  output logic [y_cord_width_p-1:0] pkt_y_o,
  output logic [x_cord_width_p-1:0] pkt_src_x_o,
  output logic [y_cord_width_p-1:0] pkt_src_y_o,
  input  logic                      resp_v_i,
  output logic                      busy_o,
  output logic                      finish_o,
  output logic                      err_o
);
  localparam int AW = addr_width_p;
  localparam int LW = addr_width_p + 1;
  localparam int CW = $clog2(max_out_credits_p + 1);
  localparam logic [CW-1:0] MAXC = CW'(max_out_credits_p);
  localparam logic [CW-1:0] ONEC = CW'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_e;

  state_e                    state_q;
  logic [AW-1:0]             src_q, dst_q, tag_q;
  logic [LW-1:0]             len_q, rd_idx_q, sent_q;
  logic [x_cord_width_p-1:0] dx_q, myx_q;
  logic [y_cord_width_p-1:0] dy_q, myy_q;
  logic                      rd_inflight_q;
  logic [1:0][data_width_p-1:0] fdata_q;
  logic [1:0][AW-1:0]        faddr_q;
  logic                      rptr_q, wptr_q;
  logic [1:0]                cnt_q, cnt_d;
  logic [CW-1:0]             credits_q, credits_d;
  logic                      err_q, err_set;

  logic                      fifo_ne, pkt_v, send, mem_rd, push, pop, last_send;
  logic [data_width_p-1:0]   head_data;
  logic [AW-1:0]             head_addr;

  // A word returning from SRAM is visible at the head the same cycle it lands,
  // so an empty FIFO costs no extra cycle of latency.
  assign fifo_ne   = (cnt_q != 2'd0);
  assign pkt_v     = (state_q == FETCH) && (fifo_ne || rd_inflight_q) && (credits_q != '0);
  assign send      = pkt_v && pkt_ready_i;
  assign head_data = fifo_ne ? fdata_q[rptr_q] : mem_data_i;
  assign head_addr = fifo_ne ? faddr_q[rptr_q] : tag_q;
  assign mem_rd    = (state_q == FETCH) && (rd_idx_q < len_q)
                   && ((cnt_q + {1'b0, rd_inflight_q}) < 2'd2);
  assign push      = rd_inflight_q && !(send && !fifo_ne);
  assign pop       = send && fifo_ne;
  assign last_send = send && ((sent_q + LW'(1)) == len_q);
  assign cnt_d     = cnt_q + {1'b0, push} - {1'b0, pop};

  always_comb begin
    credits_d = credits_q;
    err_set   = 1'b0;
    if (resp_v_i && !send) begin
      if (credits_q == MAXC) err_set = 1'b1;
      else                   credits_d = credits_q + ONEC;
    end else if (send && !resp_v_i) begin
      credits_d = credits_q - ONEC;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fdata_q[wptr_q] <= mem_data_i;
      faddr_q[wptr_q] <= tag_q;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q       <= IDLE;
      src_q         <= '0;
      dst_q         <= '0;
      tag_q         <= '0;
      len_q         <= '0;
      rd_idx_q      <= '0;
      sent_q        <= '0;
      dx_q          <= '0;
      dy_q          <= '0;
      myx_q         <= '0;
      myy_q         <= '0;
      rd_inflight_q <= 1'b0;
      rptr_q        <= 1'b0;
      wptr_q        <= 1'b0;
      cnt_q         <= '0;
      credits_q     <= MAXC;
      err_q         <= 1'b0;
    end else begin
      myx_q         <= my_x_i;
      myy_q         <= my_y_i;
      credits_q     <= credits_d;
      if (err_set) err_q <= 1'b1;
      rd_inflight_q <= mem_rd;
      if (mem_rd) begin
        tag_q    <= dst_q + rd_idx_q[AW-1:0];
        rd_idx_q <= rd_idx_q + LW'(1);
      end
      cnt_q <= cnt_d;
      if (push) wptr_q <= ~wptr_q;
      if (pop)  rptr_q <= ~rptr_q;
      if (send) sent_q <= sent_q + LW'(1);
      case (state_q)
        IDLE, DONE: if (start_i) begin
          src_q    <= src_addr_i;
          dst_q    <= dst_addr_i;
          len_q    <= len_i;
          dx_q     <= dest_x_i;
          dy_q     <= dest_y_i;
          rd_idx_q <= '0;
          sent_q   <= '0;
          state_q  <= (len_i == '0) ? DONE : FETCH;
        end
        FETCH:   if (last_send) state_q <= DRAIN;
        DRAIN:   if (credits_d == MAXC) state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_v_o     = mem_rd;
  assign mem_addr_o  = mem_rd ? (src_q + rd_idx_q[AW-1:0]) : '0;
  assign pkt_v_o     = pkt_v;
  assign pkt_addr_o  = pkt_v ? head_addr : '0;
  assign pkt_data_o  = pkt_v ? head_data : '0;
  assign pkt_x_o     = dx_q;
  assign pkt_y_o     = dy_q;
  assign pkt_src_x_o = myx_q;
  assign pkt_src_y_o = myy_q;
  assign busy_o      = (state_q == FETCH) || (state_q == DRAIN);
  assign finish_o    = (state_q == DONE);
  assign err_o       = err_q;
endmodule

// File: tb/tb_mesh_stream_injector.sv
// Randomized bench for mesh_stream_injector: SRAM model, ack generator and a
// packet scoreboard derived from the transfer description (src, dst, len).
module tb_mesh_stream_injector;
  localparam int AW = 10, DW = 32, XW = 2, YW = 2, MAXC = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_i, start_i, mem_v_o, pkt_v_o, pkt_ready_i, resp_v_i, busy_o, finish_o, err_o;
  logic [AW-1:0] src_addr_i, dst_addr_i, mem_addr_o, pkt_addr_o;
  logic [AW:0]   len_i;
  logic [XW-1:0] my_x_i, dest_x_i, pkt_x_o, pkt_src_x_o;
  logic [YW-1:0] my_y_i, dest_y_i, pkt_y_o, pkt_src_y_o;
  logic [DW-1:0] mem_data_i, pkt_data_o;

  mesh_stream_injector #(.x_cord_width_p(XW), .y_cord_width_p(YW), .data_width_p(DW),
                         .addr_width_p(AW), .max_out_credits_p(MAXC)) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .src_addr_i(src_addr_i),
    .dst_addr_i(dst_addr_i), .len_i(len_i), .my_x_i(my_x_i), .my_y_i(my_y_i),
    .dest_x_i(dest_x_i), .dest_y_i(dest_y_i), .mem_v_o(mem_v_o), .mem_addr_o(mem_addr_o),
    .mem_data_i(mem_data_i), .pkt_v_o(pkt_v_o), .pkt_ready_i(pkt_ready_i),
    .pkt_addr_o(pkt_addr_o), .pkt_data_o(pkt_data_o), .pkt_x_o(pkt_x_o), .pkt_y_o(pkt_y_o),
    .pkt_src_x_o(pkt_src_x_o), .pkt_src_y_o(pkt_src_y_o), .resp_v_i(resp_v_i),
    .busy_o(busy_o), .finish_o(finish_o), .err_o(err_o));

  logic [DW-1:0] sram [0:1023];
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model state
  int cyc = 0, ready_mode = 0, resp_mode = 0, rdly = 3;
  int m_src, m_dst, m_len, m_dx, m_dy, m_mx, m_my;
  int exp_a[$];
  logic [DW-1:0] exp_d[$];
  int pend[$];
  int reads, n_sent, n_ack, cred_m = MAXC, first_v, start_cyc, last_ack;
  bit err_m = 0, xfer_on = 0, hold = 0;
  logic [AW-1:0] hold_a;
  logic [DW-1:0] hold_d;

  task automatic tick();
    logic v, rdy, rsp, iss;
    logic [AW-1:0] ia;
    @(negedge clk);
    v = pkt_v_o; rdy = pkt_ready_i; rsp = resp_v_i; iss = mem_v_o; ia = mem_addr_o;
    chk("err", 64'(err_o), 64'(err_m));
    if (hold) begin
      chk("hold_v", 64'(v), 64'(1));
      chk("hold_addr", 64'(pkt_addr_o), 64'(hold_a));
      chk("hold_data", 64'(pkt_data_o), 64'(hold_d));
    end
    if (v) chk("v_no_credit", 64'(cred_m == 0), 64'(0));
    if (v && first_v < 0) first_v = cyc;
    if (iss) begin
      chk("rd_ahead", 64'((reads - n_sent) >= 2), 64'(0));
      chk("rd_over", 64'(reads >= m_len), 64'(0));
      chk("rd_addr", 64'(ia), 64'((m_src + reads) % 1024));
      reads++;
    end
    if (xfer_on && finish_o) begin
      chk("fin_acks", 64'(n_ack), 64'(m_len));
      chk("fin_lat", 64'(cyc - last_ack), 64'(1));
      xfer_on = 0;
    end
    if (v && rdy) begin
      if (exp_a.size() == 0) chk("extra_pkt", 64'(1), 64'(0));
      else begin
        chk("pkt_addr", 64'(pkt_addr_o), 64'(exp_a[0]));
        chk("pkt_data", 64'(pkt_data_o), 64'(exp_d[0]));
        chk("pkt_xy", 64'({pkt_x_o, pkt_y_o}), 64'((m_dx << YW) | m_dy));
        chk("pkt_src", 64'({pkt_src_x_o, pkt_src_y_o}), 64'((m_mx << YW) | m_my));
        void'(exp_a.pop_front());
        void'(exp_d.pop_front());
      end
      n_sent++;
      if (resp_mode == 0)      pend.push_back(cyc + rdly);
      else if (resp_mode == 1) pend.push_back(cyc + int'($urandom_range(1, 5)));
    end
    if (rsp) begin n_ack++; last_ack = cyc; end
    if (rsp && !(v && rdy)) begin
      if (cred_m == MAXC) err_m = 1; else cred_m++;
    end else if (!rsp && v && rdy) cred_m--;
    hold = v && !rdy;
    hold_a = pkt_addr_o; hold_d = pkt_data_o;
    @(posedge clk); #1;
    cyc++;
    mem_data_i  = iss ? sram[ia] : DW'($urandom);
    pkt_ready_i = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? (cyc % 3 == 0)
                : 1'($urandom_range(0, 1));
    resp_v_i = 1'b0;
    if (pend.size() > 0 && pend[0] <= cyc) begin
      resp_v_i = 1'b1;
      void'(pend.pop_front());
    end
  endtask

  task automatic start_xfer(input int src, dst, len, dx, dy, mx, my);
    src_addr_i = AW'(src); dst_addr_i = AW'(dst); len_i = (AW+1)'(len);
    dest_x_i = XW'(dx); dest_y_i = YW'(dy); my_x_i = XW'(mx); my_y_i = YW'(my);
    m_src = src; m_dst = dst; m_len = len; m_dx = dx; m_dy = dy; m_mx = mx; m_my = my;
    exp_a.delete(); exp_d.delete();
    for (int i = 0; i < len; i++) begin
      exp_a.push_back((dst + i) % 1024);
      exp_d.push_back(sram[(src + i) % 1024]);
    end
    reads = 0; n_sent = 0; n_ack = 0; first_v = -1; start_cyc = cyc; last_ack = -100;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    xfer_on = (len > 0);
  endtask

  task automatic wait_fin(input int budget);
    int k = 0;
    while (xfer_on && k < budget) begin tick(); k++; end
    chk("fin_timeout", 64'(xfer_on), 64'(0));
    chk("n_pkt", 64'(n_sent), 64'(m_len));
    chk("n_rd", 64'(reads), 64'(m_len));
    chk("busy_end", 64'(busy_o), 64'(0));
    xfer_on = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem"}, 64'({mem_v_o, mem_addr_o}), 64'(0));
    chk({tag, "_pkt"}, 64'({pkt_v_o, pkt_addr_o, pkt_data_o}), 64'(0));
    chk({tag, "_coord"}, 64'({pkt_x_o, pkt_y_o, pkt_src_x_o, pkt_src_y_o}), 64'(0));
    chk({tag, "_stat"}, 64'({busy_o, finish_o, err_o}), 64'(0));
  endtask

  initial begin
    int owed, k;
    for (int i = 0; i < 1024; i++) sram[i] = $urandom;
    reset_i = 0; start_i = 0; src_addr_i = '0; dst_addr_i = '0; len_i = '0;
    my_x_i = '0; my_y_i = '0; dest_x_i = '0; dest_y_i = '0;
    mem_data_i = '0; pkt_ready_i = 1'b1; resp_v_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_all_zero("reset");
    reset_i = 1;
    tick();

    // zero-length transfer from IDLE
    start_xfer(5, 5, 0, 1, 1, 0, 0);
    chk("len0_fin", 64'(finish_o), 64'(1));
    chk("len0_quiet", 64'({busy_o, mem_v_o, pkt_v_o}), 64'(0));

    // basic stream, ack 3 cycles after each send
    ready_mode = 0; resp_mode = 0; rdly = 3;
    start_xfer('h010, 'h200, 4, 1, 1, 0, 0);
    tick();
    chk("busy_mid", 64'(busy_o), 64'(1));
    chk("fin_drop", 64'(finish_o), 64'(0));
    wait_fin(100);
    chk("first_lat", 64'(first_v - start_cyc), 64'(2));

    // backpressure 1,0,0 pattern
    ready_mode = 1;
    start_xfer(100, 300, 6, 2, 3, 1, 2);
    wait_fin(200);

    // address wrap
    ready_mode = 0;
    start_xfer('h3FE, 'h3FF, 3, 3, 0, 2, 1);
    wait_fin(100);

    // spurious ack while DONE
    resp_v_i = 1'b1;
    tick();
    tick();
    chk("err_sticky", 64'(err_o), 64'(1));

    // credit stall with acks withheld
    resp_mode = 2;
    start_xfer(200, 40, 8, 1, 2, 3, 0);
    repeat (12) tick();
    chk("stall_sent", 64'(n_sent), 64'(MAXC));
    chk("stall_v", 64'(pkt_v_o), 64'(0));
    resp_v_i = 1'b1;
    tick();
    repeat (6) tick();
    chk("stall_one", 64'(n_sent), 64'(MAXC + 1));
    chk("stall_fin", 64'(finish_o), 64'(0));
    resp_mode = 0; rdly = 2;
    owed = n_sent - n_ack;
    for (int i = 0; i < owed; i++) pend.push_back(cyc + i);
    wait_fin(100);

    // randomized transfers
    ready_mode = 2; resp_mode = 1;
    repeat (6) begin
      start_xfer(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                 int'($urandom_range(1, 20)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)));
      wait_fin(400);
    end

    // maximum length
    ready_mode = 0; resp_mode = 0; rdly = 1;
    start_xfer(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1024, 2, 1, 1, 3);
    wait_fin(3000);

    // reset mid-transfer, then a clean restart
    rdly = 3;
    start_xfer(50, 60, 5, 1, 2, 3, 3);
    k = 0;
    while (n_sent < 2 && k < 20) begin tick(); k++; end
    chk("pre_reset_sent", 64'(n_sent), 64'(2));
    reset_i = 0;
    #1 chk_all_zero("abort");
    @(posedge clk); #1;
    cyc++;
    reset_i = 1;
    cred_m = MAXC; err_m = 0; hold = 0; xfer_on = 0;
    pend.delete(); exp_a.delete(); exp_d.delete();
    resp_v_i = 1'b0; reads = 0; n_sent = 0; m_len = 0;
    repeat (3) tick();
    chk("abort_no_pkt", 64'(n_sent), 64'(0));
    start_xfer(7, 8, 2, 1, 1, 2, 2);
    wait_fin(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mesh_stream_injector.md
Name: mesh_stream_injector

Overview:
- Upstream feeder for mesh_nn_accelerator: streams a block of words from a local SRAM into the mesh as remote-store packets addressed to one destination tile.
- Handles the 1-cycle SRAM read latency, valid/ready backpressure on the link and credit-based flow control. Asserts finish_o once every store has been acknowledged.

Parameters:
x_cord_width_p, 2, mesh X coordinate width
y_cord_width_p, 2, mesh Y coordinate width
data_width_p, 32, packet payload / SRAM word width
addr_width_p, 10, SRAM and remote address width
max_out_credits_p, 4, max unacknowledged stores in flight (>=1)

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous, active-low reset
start_i  in  1  start a transfer (sampled in IDLE/DONE only)
src_addr_i  in  addr_width_p  first local SRAM word
dst_addr_i  in  addr_width_p  first remote word address
len_i  in  addr_width_p+1  word count, 0..2^addr_width_p
my_x_i / my_y_i  in  x/y_cord_width_p  own tile coordinates (source field)
dest_x_i / dest_y_i  in  x/y_cord_width_p  destination tile
mem_v_o  out  1  SRAM read enable
mem_addr_o  out  addr_width_p  SRAM read address
mem_data_i  in  data_width_p  read data, valid exactly 1 cycle after mem_v_o
pkt_v_o  out  1  packet valid
pkt_ready_i  in  1  link accepts packet
pkt_addr_o  out  addr_width_p  remote address
pkt_data_o  out  data_width_p  payload
pkt_x_o / pkt_y_o  out  x/y_cord_width_p  destination coordinates
pkt_src_x_o / pkt_src_y_o  out  x/y_cord_width_p  source coordinates
resp_v_i  in  1  one store acknowledged (returns one credit)
busy_o  out  1  high in FETCH or DRAIN
finish_o  out  1  high in DONE
err_o  out  1  sticky credit-overflow error

Behaviour:
- Reset (reset_i low, async): state IDLE. All outputs 0. Credits = max_out_credits_p. FIFO empty, counters 0, err_o 0.
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE/DONE with start_i=1:
  - Latch src, dst, len, dest coordinates. Capture my_x_i/my_y_i each cycle.
  - len_i=0: go to DONE next cycle.
  - len_i>0: go to FETCH. finish_o drops the cycle after start_i.
- FETCH:
  - Read issue: mem_v_o=1 when reads_issued < len and (fifo_count + read_in_flight) < 2. mem_addr_o = src + reads_issued, wrapping mod 2^addr_width_p.
  - Returning data: written into a 2-entry FIFO the cycle after issue, tagged with dst + index (same wrap).
  - Packet output: pkt_v_o = FIFO non-empty AND credits > 0, driving the FIFO head. Transfer occurs when pkt_v_o && pkt_ready_i; the head pops and credits decrement.
  - pkt_v_o is never withdrawn and the payload is never changed while waiting for ready, unless credits are exhausted. pkt_v_o only rises with credits > 0.
  - Throughput: 1 packet/cycle with ready and credits held high. First pkt_v_o 2 cycles after the start_i cycle.
  - After the last packet transfers, go to DRAIN.
- DRAIN: go to DONE when credits == max_out_credits_p. A same-cycle resp_v_i is counted first.
- Credits:
  - Same-cycle send and resp_v_i leave the count unchanged.
  - resp_v_i with credits already at max (and no send that cycle): count saturates and err_o sets. err_o clears only on reset.
- resp_v_i in IDLE/DONE is handled by the same credit rules.
- start_i outside IDLE/DONE is ignored.
- Reset mid-transfer: immediate abort to the reset state. Queued data is discarded; no further packets.
- len = 2^addr_width_p is legal. The address counter wraps and the index counter is addr_width_p+1 bits.

Test Plan:
- Basic stream: src=0x010, dst=0x200, len=4, dest=(1,1), ready=1, resp 3 cycles after each send -> packets addr 0x200..0x203 carry SRAM[0x10..0x13]; finish_o high after 4th resp; pkt_x/y=1, src x/y=0.
- Backpressure: len=6, pkt_ready_i toggling 1,0,0,1... -> no packet lost or duplicated; payload stable while v&&!ready; mem_v_o stalls once FIFO+in-flight=2.
- Credit stall: max_out_credits_p=4, resp withheld, len=8 -> exactly 4 packets sent then pkt_v_o=0. Then 1 resp -> exactly 1 more packet. finish_o only after all 8 acked.
- Wrap: src=0x3FE, dst=0x3FF, len=3 -> reads 0x3FE,0x3FF,0x000; pkt_addr 0x3FF,0x000,0x001.
- Edge cases: len=0 -> DONE in 1 cycle, no mem_v_o/pkt_v_o. Spurious resp_v_i in IDLE -> err_o=1, credits stay 4.
- Reset mid-transfer: drop reset_i after 2 of 5 packets -> all outputs 0 immediately. A new start with len=2 completes cleanly.
